// File: rtl/spi_slave_ram.sv
// SPI slave clocked by the master sclk (== clk) with an embedded byte RAM.
// Decodes 10-bit {cmd, payload} frames; read-data frames return one byte on MISO.
module spi_slave_ram #(
  parameter int unsigned MEM_DEPTH = 256
) (
  input  logic clk,
  input  logic rst_n,
  input  logic ss_n,
  input  logic MOSI,
  output logic MISO,
  output logic valid_MISO,
  output logic sready,
  output logic frame_abort
);

  localparam int unsigned AW      = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;
  localparam int unsigned DATA_W  = 8;
  localparam int unsigned FRAME_W = 10;
  localparam int unsigned CNT_W   = 4;

  localparam logic [CNT_W-1:0] RX_LAST = CNT_W'(FRAME_W - 1);
  localparam logic [CNT_W-1:0] TX_LAST = CNT_W'(DATA_W);

  localparam logic [1:0] CMD_WR_ADDR = 2'b00;
  localparam logic [1:0] CMD_WR_DATA = 2'b01;
  localparam logic [1:0] CMD_RD_ADDR = 2'b10;
  localparam logic [1:0] CMD_RD_DATA = 2'b11;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_RX      = 3'd1,
    ST_EXEC    = 3'd2,
    ST_TX      = 3'd3,
    ST_WAIT_SS = 3'd4
  } state_t;

  state_t              state_q, state_d;
  logic [CNT_W-1:0]    bit_cnt_q, bit_cnt_d;
  logic [FRAME_W-1:0]  rx_shift_q, rx_shift_d;
  logic [DATA_W-1:0]   wr_addr_q, wr_addr_d;
  logic [DATA_W-1:0]   rd_addr_q, rd_addr_d;
  logic [DATA_W-1:0]   tx_reg_q, tx_reg_d;
  logic                miso_d, valid_d, sready_d, abort_d;
  logic                mem_we;
  logic [1:0]          cmd;
  logic [DATA_W-1:0]   payload;

  logic [DATA_W-1:0]   mem [MEM_DEPTH];

  assign cmd     = rx_shift_q[FRAME_W-1:DATA_W];
  assign payload = rx_shift_q[DATA_W-1:0];

  // State and registered outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      bit_cnt_q   <= '0;
      rx_shift_q  <= '0;
      wr_addr_q   <= '0;
      rd_addr_q   <= '0;
      tx_reg_q    <= '0;
      MISO        <= 1'b0;
      valid_MISO  <= 1'b0;
      sready      <= 1'b1;
      frame_abort <= 1'b0;
    end else begin
      state_q     <= state_d;
      bit_cnt_q   <= bit_cnt_d;
      rx_shift_q  <= rx_shift_d;
      wr_addr_q   <= wr_addr_d;
      rd_addr_q   <= rd_addr_d;
      tx_reg_q    <= tx_reg_d;
      MISO        <= miso_d;
      valid_MISO  <= valid_d;
      sready      <= sready_d;
      frame_abort <= abort_d;
    end
  end

  // Memory contents are intentionally not reset
  always_ff @(posedge clk) begin
    if (mem_we) begin
      mem[wr_addr_q[AW-1:0]] <= payload;
    end
  end

  // Next-state and next-output logic
  always_comb begin
    state_d    = state_q;
    bit_cnt_d  = bit_cnt_q;
    rx_shift_d = rx_shift_q;
    wr_addr_d  = wr_addr_q;
    rd_addr_d  = rd_addr_q;
    tx_reg_d   = tx_reg_q;
    miso_d     = MISO;
    valid_d    = valid_MISO;
    abort_d    = 1'b0;
    mem_we     = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (!ss_n) begin
          state_d   = ST_RX;
          bit_cnt_d = '0;
        end
      end

      ST_RX: begin
        if (ss_n) begin
          state_d   = ST_IDLE;
          abort_d   = 1'b1;
          bit_cnt_d = '0;
        end else begin
          rx_shift_d = {rx_shift_q[FRAME_W-2:0], MOSI};
          if (bit_cnt_q == RX_LAST) begin
            state_d   = ST_EXEC;
            bit_cnt_d = '0;
          end else begin
            bit_cnt_d = bit_cnt_q + CNT_W'(1);
          end
        end
      end

      ST_EXEC: begin
        bit_cnt_d = '0;
        state_d   = ST_WAIT_SS;
        case (cmd)
          CMD_WR_ADDR: wr_addr_d = payload;
          CMD_WR_DATA: mem_we    = 1'b1;
          CMD_RD_ADDR: rd_addr_d = payload;
          CMD_RD_DATA: begin
            tx_reg_d = mem[rd_addr_q[AW-1:0]];
            state_d  = ST_TX;
          end
        endcase
      end

      // Eight data edges followed by one edge that drops valid
      ST_TX: begin
        if (ss_n) begin
          valid_d   = 1'b0;
          miso_d    = 1'b0;
          abort_d   = 1'b1;
          state_d   = ST_IDLE;
          bit_cnt_d = '0;
        end else if (bit_cnt_q == TX_LAST) begin
          valid_d   = 1'b0;
          miso_d    = 1'b0;
          state_d   = ST_WAIT_SS;
          bit_cnt_d = '0;
        end else begin
          miso_d    = tx_reg_q[DATA_W-1];
          valid_d   = 1'b1;
          tx_reg_d  = {tx_reg_q[DATA_W-2:0], 1'b0};
          bit_cnt_d = bit_cnt_q + CNT_W'(1);
        end
      end

      ST_WAIT_SS: begin
        if (ss_n) begin
          state_d = ST_IDLE;
        end
      end

      default: begin
        state_d   = ST_IDLE;
        bit_cnt_d = '0;
      end
    endcase

    sready_d = (state_d == ST_IDLE);
  end

endmodule

// File: tb/tb_spi_slave_ram.sv
// Directed bench for spi_slave_ram: table of master frames plus hand-written
// abort and reset sequences, with expected bytes worked out by hand.
module tb_spi_slave_ram;

  logic clk;
  logic rst_n;
  logic ss_n;
  logic mosi;
  logic miso;
  logic valid_miso;
  logic sready;
  logic frame_abort;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [9:0] frame;
    logic       is_read;
    logic [7:0] exp;
  } vec_t;

  vec_t vecs[$];

  spi_slave_ram #(.MEM_DEPTH(256)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .ss_n       (ss_n),
    .MOSI       (mosi),
    .MISO       (miso),
    .valid_MISO (valid_miso),
    .sready     (sready),
    .frame_abort(frame_abort)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, time %0t required < 100000", $time);
    $fatal(1);
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic add_vec(input logic [9:0] f, input logic r, input logic [7:0] e);
    vec_t v;
    v.frame   = f;
    v.is_read = r;
    v.exp     = e;
    vecs.push_back(v);
  endtask

  task automatic wait_ready(input string name);
    int n = 0;
    @(negedge clk);
    while (!sready && n < 30) begin
      @(negedge clk);
      n++;
    end
    check({name, "_sready_return"}, 32'(sready), 32'd1);
  endtask

  // Master model: ss_n low in T1, bits in T2..T11; read frames hold ss_n through T21
  task automatic send_frame(input logic [9:0] f, input logic is_read,
                            output logic [7:0] rd, output int vcnt,
                            output logic vok, output logic srhi);
    rd   = 8'h00;
    vcnt = 0;
    vok  = 1'b1;
    srhi = 1'b0;
    @(posedge clk); #1;
    ss_n = 1'b0;
    mosi = 1'b0;
    for (int i = 9; i >= 0; i--) begin
      @(posedge clk); #1;
      mosi = f[i];
      @(negedge clk);
      srhi = srhi | sready;
    end
    @(posedge clk); #1;
    if (!is_read) begin
      ss_n = 1'b1;
      mosi = 1'b0;
    end else begin
      for (int c = 12; c <= 22; c++) begin
        if (c == 22) begin
          ss_n = 1'b1;
          mosi = 1'b0;
        end
        @(negedge clk);
        if (valid_miso !== ((c >= 14) && (c <= 21))) vok = 1'b0;
        if (valid_miso) begin
          rd = {rd[6:0], miso};
          vcnt++;
        end
        @(posedge clk); #1;
      end
    end
  endtask

  task automatic do_frame(input string name, input logic [9:0] f,
                          input logic is_read, input logic [7:0] exp);
    logic [7:0] rd;
    int         vcnt;
    logic       vok;
    logic       srhi;
    send_frame(f, is_read, rd, vcnt, vok, srhi);
    check({name, "_sready_low"}, 32'(srhi), 32'd0);
    if (is_read) begin
      check({name, "_valid_cycles"}, 32'(vcnt), 32'd8);
      check({name, "_valid_window"}, 32'(vok), 32'd1);
      check({name, "_data"}, 32'(rd), 32'(exp));
    end
    wait_ready(name);
  endtask

  // Drive ss_n low and the first n bits of f; returns inside the cycle of the last bit
  task automatic start_frame(input logic [9:0] f, input int n);
    @(posedge clk); #1;
    ss_n = 1'b0;
    mosi = 1'b0;
    for (int i = 0; i < n; i++) begin
      @(posedge clk); #1;
      mosi = f[9-i];
    end
  endtask

  initial begin
    int         pulses;
    int         bits;
    logic [7:0] rx;

    rst_n = 1'b0;
    ss_n  = 1'b1;
    mosi  = 1'b0;

    // Reset values
    repeat (3) @(negedge clk);
    check("rst_sready", 32'(sready), 32'd1);
    check("rst_valid", 32'(valid_miso), 32'd0);
    check("rst_miso", 32'(miso), 32'd0);
    check("rst_abort", 32'(frame_abort), 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    check("post_rst_sready", 32'(sready), 32'd1);

    add_vec(10'h012, 1'b0, 8'h00);
    add_vec(10'h1A5, 1'b0, 8'h00);
    add_vec(10'h212, 1'b0, 8'h00);
    add_vec(10'h300, 1'b1, 8'hA5);
    add_vec(10'h0FF, 1'b0, 8'h00);
    add_vec(10'h13C, 1'b0, 8'h00);
    add_vec(10'h000, 1'b0, 8'h00);
    add_vec(10'h1C3, 1'b0, 8'h00);
    add_vec(10'h2FF, 1'b0, 8'h00);
    add_vec(10'h300, 1'b1, 8'h3C);
    add_vec(10'h200, 1'b0, 8'h00);
    add_vec(10'h300, 1'b1, 8'hC3);
    add_vec(10'h2FF, 1'b0, 8'h00);
    add_vec(10'h3AB, 1'b1, 8'h3C);
    add_vec(10'h2FF, 1'b0, 8'h00);
    add_vec(10'h300, 1'b1, 8'h3C);

    foreach (vecs[k]) begin
      do_frame($sformatf("vec%0d", k), vecs[k].frame, vecs[k].is_read, vecs[k].exp);
    end

    // Abort mid-RX: five bits of 0x1FF then ss_n high
    do_frame("abrx_wa", 10'h012, 1'b0, 8'h00);
    start_frame(10'h1FF, 5);
    @(posedge clk); #1;
    ss_n = 1'b1;
    mosi = 1'b0;
    pulses = 0;
    repeat (6) begin
      @(negedge clk);
      if (frame_abort) pulses++;
    end
    check("abrx_pulses", 32'(pulses), 32'd1);
    wait_ready("abrx");
    do_frame("abrx_ra", 10'h212, 1'b0, 8'h00);
    do_frame("abrx_rd", 10'h300, 1'b1, 8'hA5);

    // Abort during TX after three valid cycles
    start_frame(10'h300, 10);
    @(posedge clk); #1;
    bits = 0;
    rx   = 8'h00;
    for (int c = 12; c <= 16; c++) begin
      @(negedge clk);
      if (valid_miso) begin
        rx = {rx[6:0], miso};
        bits++;
      end
      @(posedge clk); #1;
    end
    ss_n = 1'b1;
    @(negedge clk);
    if (valid_miso) begin
      rx = {rx[6:0], miso};
      bits++;
    end
    check("abtx_bits", 32'(bits), 32'd4);
    check("abtx_partial", 32'(rx[3:0]), 32'hA);
    @(posedge clk); #1;
    @(negedge clk);
    check("abtx_valid_low", 32'(valid_miso), 32'd0);
    check("abtx_abort", 32'(frame_abort), 32'd1);
    check("abtx_sready", 32'(sready), 32'd1);
    @(negedge clk);
    check("abtx_abort_once", 32'(frame_abort), 32'd0);
    wait_ready("abtx");
    do_frame("abtx_rd", 10'h300, 1'b1, 8'hA5);

    // Reset mid-RX of 0x1FF with wr_addr = 0x12
    do_frame("rst_wa", 10'h012, 1'b0, 8'h00);
    start_frame(10'h1FF, 5);
    @(posedge clk); #1;
    rst_n = 1'b0;
    #1;
    check("midrst_sready", 32'(sready), 32'd1);
    check("midrst_valid", 32'(valid_miso), 32'd0);
    check("midrst_miso", 32'(miso), 32'd0);
    check("midrst_abort", 32'(frame_abort), 32'd0);
    ss_n = 1'b1;
    mosi = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    wait_ready("midrst");
    do_frame("midrst_rd0", 10'h300, 1'b1, 8'hC3);
    do_frame("midrst_wr0", 10'h15A, 1'b0, 8'h00);
    do_frame("midrst_rd5a", 10'h300, 1'b1, 8'h5A);
    do_frame("midrst_ra", 10'h212, 1'b0, 8'h00);
    do_frame("midrst_rd12", 10'h300, 1'b1, 8'hA5);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/spi_slave_ram.md
# spi_slave_ram

SPI slave with an embedded single-port byte memory. It sits directly downstream of `SPI_Master`: `sclk` equals `clk`, so all signals are synchronous to `clk`. The block receives 10-bit command frames on `MOSI` while `ss_n` is low and executes write-address, write-data, read-address and read-data commands. For read-data it returns one byte on `MISO`, qualified by `valid_MISO`.

## Interface
- `MEM_DEPTH`, default 256: number of 8-bit memory words. The address is the low `log2(MEM_DEPTH)` bits of the 8-bit payload.
- `clk` input 1: clock; same net as the master `sclk`.
- `rst_n` input 1: reset, asynchronous, active-low.
- `ss_n` input 1: slave select, active-low; driven by the master.
- `MOSI` input 1: serial command/data, MSB first.
- `MISO` output 1: serial read data, MSB first.
- `valid_MISO` output 1: qualifies `MISO`; high for exactly 8 consecutive cycles per read-data frame.
- `sready` output 1: slave idle and able to accept a frame.
- `frame_abort` output 1: one-cycle pulse when `ss_n` rises mid-frame.

## Operation
- **Frame format:** `{cmd[1:0], payload[7:0]}`, shifted in MSB first.
  - `cmd` 00: `wr_addr <= payload`.
  - `cmd` 01: `mem[wr_addr] <= payload`.
  - `cmd` 10: `rd_addr <= payload`.
  - `cmd` 11: read `mem[rd_addr]` and transmit it; payload ignored.
- **Addresses:** `wr_addr` and `rd_addr` are not auto-incremented.
- **State machine (registered):**
  - IDLE: `sready=1`. On a clock edge sampling `ss_n=0`, go to RX with `bit_cnt=0`. The `MOSI` value sampled on that edge is discarded as the turnaround bit.
  - RX: each edge shifts `MOSI` into `rx_shift[9:0]` and increments `bit_cnt`. The edge capturing the 10th bit goes to EXEC. `ss_n` sampled high before that edge goes to IDLE and pulses `frame_abort`; no register or memory is updated.
  - EXEC (1 cycle): performs the decoded command. For `cmd`=11, `tx_reg <= mem[rd_addr]` and the next state is TX; otherwise the next state is WAIT_SS.
  - TX (9 cycles):
    - On edges 1–8, `MISO <= tx_reg[7]`, `valid_MISO <= 1`, and `tx_reg` shifts left.
    - On edge 9, `valid_MISO <= 0`, `MISO <= 0`, and the next state is WAIT_SS.
    - `ss_n` sampled high during TX aborts: `valid_MISO <= 0`, pulse `frame_abort`, go to IDLE.
  - WAIT_SS: stay until `ss_n` is sampled high, then go to IDLE.
- **Memory:** contents are not reset. Reading a never-written location returns an unspecified value.
- **Payload width:** `wr_addr`/`rd_addr` are 8-bit registers, reset to 0. For `MEM_DEPTH` below 256, upper payload bits are ignored (address wraps).

## Timing
- **Reset values:** `MISO=0`, `valid_MISO=0`, `sready=1`, `frame_abort=0`, state IDLE, `bit_cnt=0`, `wr_addr=0`, `rd_addr=0`, `tx_reg=0`.
- **Reset mid-frame:** returns to IDLE immediately. A partial frame has no effect; memory is unaffected unless the EXEC write edge has already occurred.
- **`sready`:** registered. It falls in the cycle after the IDLE→RX edge and rises in the cycle after entry to IDLE. It is never high while `ss_n` is low in a frame.
- **Frame sampling:** with `ss_n` first low in cycle T1, bits b9..b0 are sampled at the ends of T2..T11.
  - Master write frame: `ss_n` is low T1..T11.
  - EXEC occurs in T12. A memory write is visible to a read-data frame issued immediately afterwards.
- **Read latency:**
  - `valid_MISO` is high T14..T21, carrying b7..b0.
  - The 3-cycle gap T11→T14 carries `valid_MISO=0`, and `MISO` holds its previous value.
  - `valid_MISO` is low from T22.
- **Back-to-back frames:** the slave must pass through WAIT_SS and IDLE. `ss_n` falling in the same cycle the slave enters IDLE is accepted on the next edge.
- **`ss_n` high during EXEC:** for a write frame this is normal. The command still executes, then WAIT_SS exits on the next edge.

## Test plan
1. Reset with `ss_n=1` → `sready=1`, `valid_MISO=0`, `MISO=0`, `frame_abort=0`.
2. Via `SPI_Master`: frames 0x012 (`wr_addr`=0x12), then 0x1A5 (`mem[0x12]=0xA5`), then 0x212 (`rd_addr`=0x12), then 0x300.
   - Required: `valid_MISO` high exactly 8 cycles, T14..T21 of the read-data frame.
   - Required: `MISO` sequence 1,0,1,0,0,1,0,1; master `data_out`=0xA5 with `done` pulsed.
3. Write 0x3C to 0xFF, then 0xC3 to 0x00, then read both → 0x3C and 0xC3. Confirms no address cross-talk or auto-increment.
4. Raw drive: `ss_n` low, 5 bits of 0x1FF, then `ss_n` high.
   - Required: `frame_abort` pulses once, memory unchanged (re-read returns the previous value), `sready` returns to 1.
5. Abort during TX: raise `ss_n` after the 3rd `valid_MISO` cycle → `valid_MISO` low on the next edge, `frame_abort` pulse, IDLE; the next read returns the full byte.
6. Assert `rst_n`=0 mid-RX of frame 0x1FF → outputs at reset values immediately, target memory location unchanged, the next complete frame executes normally.
